alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   32-bit integer ALU for the single-cycle/pipelined MIPS-style CPU datapath.
//   Computes one of 16 operations selected by aluc on operands a and b.
//   Result and four status flags are registered: they update one cycle after inputs.
// PARAMETERS
//   (none) - datapath fixed at 32 bits; aluc fixed at 4 bits
// PORTS
//   clk       in   1   clock, all state updates on rising edge
//   rst       in   1   synchronous, active-high reset
//   a         in   32  operand A (shift amount source for shifts: a[4:0])
//   b         in   32  operand B (shifted value for shifts, immediate for LUI)
//   aluc      in   4   operation select
//   r         out  32  registered result
//   zero      out  1   registered: r == 0
//   negative  out  1   registered: r[31]
//   carry     out  1   registered carry/borrow/shift-out (see below)
//   overflow  out  1   registered signed overflow (ADD/SUB only)
// BEHAVIOUR
//   - Rising clk with rst=1: r=0, zero=0, negative=0, carry=0, overflow=0.
//     rst has priority over any operation, including mid-stream.
//   - Rising clk with rst=0: all outputs load the combinational result of the
//     current a, b, aluc. Latency exactly 1 cycle; new op accepted every cycle.
//   - aluc encoding (r value; carry; overflow):
//     0000 ADDU  a+b mod 2^32; carry = bit 32 of a+b; ovf 0
//     0010 ADD   a+b; carry = bit 32; ovf = a[31]==b[31] && r[31]!=a[31]
//     0001 SUBU  a-b mod 2^32; carry = borrow (a<b unsigned); ovf 0
//     0011 SUB   a-b; carry = borrow; ovf = a[31]!=b[31] && r[31]!=a[31]
//     0100 AND   a&b      0101 OR  a|b     0110 XOR a^b    0111 NOR ~(a|b)
//     100x LUI   {b[15:0],16'h0000}
//     1011 SLT   signed a<b ? 1 : 0
//     1010 SLTU  unsigned a<b ? 1 : 0
//     1100 SRA   b >>> a[4:0] (sign fill); carry = b[a[4:0]-1]
//     1101 SRL   b >> a[4:0] (zero fill); carry = b[a[4:0]-1]
//     111x SLL   b << a[4:0]; carry = b[32-a[4:0]]
//   - Shift amount 0: r=b, carry=0. Upper bits a[31:5] ignored for shifts.
//   - carry=0 for logic, LUI, SLT, SLTU; overflow=0 for every op except ADD/SUB.
//   - zero and negative derived from r for every op (incl. SLT/SLTU/LUI).
//   - Wrap-around: ADDU/ADD/SUBU/SUB results always truncated to 32 bits;
//     overflow never alters r.
//   - No X propagation: every aluc value decodes to a defined op.
// TESTING
//   a=0x00000011, b=0xFFFFFFFE, aluc stepped 0000..1111 one per cycle, check
//   outputs one cycle later:
//     ADDU r=0x0000000F c=1; ADD r=0x0000000F v=0; SUBU r=0x00000013 c=1;
//     SUB r=0x00000013 v=0; AND 0x00000010; OR 0xFFFFFFFF n=1; XOR 0xFFFFFFEF;
//     NOR 0x00000000 z=1; LUI 0xFFFE0000 n=1; SLT 0 z=1; SLTU 1;
//     SRA 0xFFFFFFFF c=1; SRL 0x00007FFF c=1; SLL 0xFFFC0000 c=1.
//   Signed overflow: ADD 0x7FFFFFFF+0x00000001 -> r=0x80000000 v=1 n=1 c=0;
//     SUB 0x80000000-0x00000001 -> r=0x7FFFFFFF v=1.
//   Zero/carry: ADDU 0xFFFFFFFF+0x00000001 -> r=0 z=1 c=1 v=0.
//   Shift by 0: SLL a=0, b=0x12345678 -> r=0x12345678 c=0.
//   Reset: assert rst for one cycle during op stream -> all outputs 0 next edge;
//     deassert -> following edge shows current op result.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath and the registered ALU.
// clk and rst stay outside the interface as plain ports.
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [31:0] r;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    modport master (
        output a, b, aluc,
        input  r, zero, negative, carry, overflow
    );

    modport slave (
        input  a, b, aluc,
        output r, zero, negative, carry, overflow
    );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: 16 ops selected by aluc; result and flags registered,
// one new operation accepted every cycle with a latency of one clock.
module alu (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADDU = 4'b0000,
        OP_SUBU = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_LUI0 = 4'b1000,
        OP_LUI1 = 4'b1001,
        OP_SLTU = 4'b1010,
        OP_SLT  = 4'b1011,
        OP_SRA  = 4'b1100,
        OP_SRL  = 4'b1101,
        OP_SLL0 = 4'b1110,
        OP_SLL1 = 4'b1111
    } op_e;

    op_e                op;
    logic [4:0]         sh;
    logic [32:0]        sum_w;
    logic [32:0]        diff_w;
    logic [32:0]        sll_w;
    logic [32:0]        srl_w;
    logic signed [32:0] sra_w;
    logic               slt;

    logic [31:0]        res;
    logic               c_n;
    logic               v_n;

    assign op     = op_e'(bus.aluc);
    assign sh     = bus.a[4:0];
    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign slt    = $signed(bus.a) < $signed(bus.b);

    // A guard bit on the far side of the shift catches the last bit shifted
    // out; with a zero shift amount it stays 0, so carry needs no special case.
    assign sll_w  = {1'b0, bus.b} << sh;
    assign srl_w  = {bus.b, 1'b0} >> sh;
    assign sra_w  = $signed({bus.b, 1'b0}) >>> sh;

    always_comb begin
        res = '0;
        c_n = 1'b0;
        v_n = 1'b0;
        case (op)
            OP_ADDU: begin
                res = sum_w[31:0];
                c_n = sum_w[32];
            end
            OP_ADD: begin
                res = sum_w[31:0];
                c_n = sum_w[32];
                v_n = (bus.a[31] == bus.b[31]) && (sum_w[31] != bus.a[31]);
            end
            OP_SUBU: begin
                res = diff_w[31:0];
                c_n = diff_w[32];
            end
            OP_SUB: begin
                res = diff_w[31:0];
                c_n = diff_w[32];
                v_n = (bus.a[31] != bus.b[31]) && (diff_w[31] != bus.a[31]);
            end
            OP_AND:           res = bus.a & bus.b;
            OP_OR:            res = bus.a | bus.b;
            OP_XOR:           res = bus.a ^ bus.b;
            OP_NOR:           res = ~(bus.a | bus.b);
            OP_LUI0, OP_LUI1: res = {bus.b[15:0], 16'h0000};
            OP_SLT:           res = {31'd0, slt};
            OP_SLTU:          res = {31'd0, diff_w[32]};
            OP_SRA: begin
                res = sra_w[32:1];
                c_n = sra_w[0];
            end
            OP_SRL: begin
                res = srl_w[32:1];
                c_n = srl_w[0];
            end
            OP_SLL0, OP_SLL1: begin
                res = sll_w[31:0];
                c_n = sll_w[32];
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.r        <= '0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
            bus.carry    <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.r        <= res;
            bus.zero     <= (res == '0);
            bus.negative <= res[31];
            bus.carry    <= c_n;
            bus.overflow <= v_n;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Randomised and directed stimulus for alu; expected responses are queued by
// the driver and checked by an independent monitor one cycle later.
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec    = 0;

    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    // Reference computed from the arithmetic meaning of each op.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
        exp_t            e;
        longint unsigned ua, ub, full, p;
        longint          sa, sb, sres, qt;
        int unsigned     sh;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a[4:0]);
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.idx = 0;
        case (op)
            4'b0000, 4'b0010: begin
                full = ua + ub;
                e.r  = full[31:0];
                e.c  = (full >= TWO32);
                sres = sa + sb;
                if (op == 4'b0010)
                    e.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'b0001, 4'b0011: begin
                full = ua + TWO32 - ub;
                e.r  = full[31:0];
                e.c  = (ua < ub);
                sres = sa - sb;
                if (op == 4'b0011)
                    e.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'b0100: e.r = a & b;
            4'b0101: e.r = a | b;
            4'b0110: e.r = a ^ b;
            4'b0111: e.r = ~(a | b);
            4'b1000, 4'b1001: begin
                full = (ub % 65536) * 65536;
                e.r  = full[31:0];
            end
            4'b1011: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1010: e.r = (ua < ub) ? 32'd1 : 32'd0;
            4'b1100, 4'b1101: begin
                p = 64'd1 << sh;
                if (op == 4'b1101) begin
                    full = ub / p;
                    e.r  = full[31:0];
                end else begin
                    qt = sb / longint'(p);
                    if (sb < 0 && (sb % longint'(p)) != 0) qt = qt - 1;
                    e.r = qt[31:0];
                end
                if (sh != 0) e.c = ((ub / (p / 2)) % 2) == 1;
            end
            default: begin
                full = ub * (64'd1 << sh);
                e.r  = full[31:0];
                e.c  = ((full / TWO32) % 2) == 1;
            end
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r_in, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op);
        exp_t e;
        @(negedge clk);
        rst      = r_in;
        bus.a    = a;
        bus.b    = b;
        bus.aluc = op;
        if (r_in) begin
            e.r = '0; e.z = 1'b0; e.n = 1'b0; e.c = 1'b0; e.v = 1'b0;
        end else begin
            e = model(a, b, op);
        end
        e.idx = vec;
        vec++;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("r",        e.idx, bus.r,                   e.r);
            check("zero",     e.idx, {31'd0, bus.zero},       {31'd0, e.z});
            check("negative", e.idx, {31'd0, bus.negative},   {31'd0, e.n});
            check("carry",    e.idx, {31'd0, bus.carry},      {31'd0, e.c});
            check("overflow", e.idx, {31'd0, bus.overflow},   {31'd0, e.v});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog vec=%0d actual=timeout required=finish", vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        bus.a = '0; bus.b = '0; bus.aluc = '0;

        step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0101);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000);

        for (int unsigned op = 0; op < 16; op++)
            step(1'b0, 32'h0000_0011, 32'hFFFF_FFFE, 4'(op));

        step(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        step(1'b0, 32'h8000_0000, 32'h0000_0001, 4'b0011);
        step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000);
        step(1'b0, 32'h0000_0000, 32'h1234_5678, 4'b1110);
        step(1'b0, 32'h0000_0000, 32'h8765_4321, 4'b1100);
        step(1'b0, 32'hFFFF_FFE0, 32'h8765_4321, 4'b1101);
        step(1'b0, 32'h0000_001F, 32'h8000_0001, 4'b1100);
        step(1'b0, 32'h0000_001F, 32'h0000_0003, 4'b1111);
        step(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1011);
        step(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1010);

        // Reset in the middle of the stream, then resume.
        step(1'b0, 32'h0000_0005, 32'h0000_0003, 4'b0001);
        step(1'b1, 32'h0000_0005, 32'h0000_0003, 4'b0000);
        step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011);

        for (int i = 0; i < 240; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = {ra[31:5], 5'($urandom_range(0, 31))};
                1: rb = 32'h8000_0000 | 32'($urandom_range(0, 3));
                2: ra = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            step(1'b0, ra, rb, 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        check("queue_drained", vec, 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
